// File: rtl/fpu_round_stage_pkg.sv
// fpu_round_stage_pkg: shared FPU rounding-mode encodings, exponent limits and field widths
package fpu_round_stage_pkg;
    localparam int DEF_EXP_W  = 11;
    localparam int DEF_FRAC_W = 52;
    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_POS_INF = 2'b10;
    localparam logic [1:0] RM_NEG_INF = 2'b11;
    localparam int EXP_MAX_FINITE = 2046;
    localparam int EXP_ALL_ONES   = 2047;
endpackage

// File: rtl/fpu_round_incr.sv
// fpu_round_incr: rounding increment decision from mode, sign, lsb, guard and sticky
module fpu_round_incr
    import fpu_round_stage_pkg::*;
(
    input  logic [1:0] rmode_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       s_i,
    output logic       inc_o
);
    // round-to-zero never increments; directed modes round away only toward their infinity
    always_comb begin
        inc_o = (rmode_i == RM_NEAREST) ? g_i & (s_i | lsb_i) :
                (rmode_i == RM_POS_INF) ? !sign_i & (g_i | s_i) :
                (rmode_i == RM_NEG_INF) ? sign_i & (g_i | s_i) : 1'b0;
    end
endmodule

// File: rtl/fpu_round_stage.sv
// fpu_round_stage: two-stage normalise/round pipeline feeding the FPU exception stage
module fpu_round_stage
    import fpu_round_stage_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [1:0]              rmode,
    input  logic                    sign_in,
    input  logic [EXP_W:0]          exponent_in,
    input  logic [FRAC_W+3:0]       mantissa_in,
    output logic                    out_valid,
    output logic [EXP_W+FRAC_W:0]   round_out,
    output logic [EXP_W:0]          exponent_out,
    output logic [1:0]              grs_out
);
    localparam int MW = FRAC_W + 4;
    logic [MW-2:0]          norm_d;
    logic [EXP_W:0]         exp1_d;
    logic                   inc_d;
    logic                   v1_q, v2_q, sign1_q, inc1_q;
    logic [EXP_W:0]         exp1_q;
    logic [FRAC_W:0]        m1_q;
    logic [1:0]             gs1_q;
    logic [FRAC_W+1:0]      sum_d;
    logic [EXP_W:0]         exp2_d;
    logic [FRAC_W-1:0]      frac2_d;
    logic [EXP_W+FRAC_W:0]  round_q;
    logic [EXP_W:0]         exp2_q;
    logic [1:0]             grs_q;

    // one-bit post-normalisation; the dropped bit folds into sticky so inexact is preserved
    always_comb begin
        norm_d = mantissa_in[MW-1] ? {mantissa_in[MW-1:2], |mantissa_in[1:0]} : mantissa_in[MW-2:0];
        exp1_d = exponent_in + (EXP_W+1)'(mantissa_in[MW-1]);
    end

    fpu_round_incr u_incr (
        .rmode_i (rmode),
        .sign_i  (sign_in),
        .lsb_i   (norm_d[2]),
        .g_i     (norm_d[1]),
        .s_i     (norm_d[0]),
        .inc_o   (inc_d)
    );

    // apply increment; carry-out renormalises, and a denormal rounding up to 1.0 becomes exponent 1
    always_comb begin
        sum_d   = {1'b0, m1_q} + (FRAC_W+2)'(inc1_q);
        exp2_d  = sum_d[FRAC_W+1] ? exp1_q + (EXP_W+1)'(1) :
                  (exp1_q == '0 && sum_d[FRAC_W]) ? (EXP_W+1)'(1) : exp1_q;
        frac2_d = sum_d[FRAC_W+1] ? '0 : sum_d[FRAC_W-1:0];
    end

    // valid bits shift on enable and clear on flush; data loads only behind a surviving valid
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            sign1_q <= 1'b0;
            inc1_q  <= 1'b0;
            exp1_q  <= '0;
            m1_q    <= '0;
            gs1_q   <= '0;
            round_q <= '0;
            exp2_q  <= '0;
            grs_q   <= '0;
        end else begin
            if (flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else if (enable) begin
                v1_q <= in_valid;
                v2_q <= v1_q;
            end
            if (enable && in_valid && !flush) begin
                sign1_q <= sign_in;
                inc1_q  <= inc_d;
                exp1_q  <= exp1_d;
                m1_q    <= norm_d[MW-2:2];
                gs1_q   <= norm_d[1:0];
            end
            if (enable && v1_q && !flush) begin
                round_q <= {sign1_q, exp2_d[EXP_W-1:0], frac2_d};
                exp2_q  <= exp2_d;
                grs_q   <= gs1_q;
            end
        end
    end

    assign out_valid    = v2_q;
    assign round_out    = round_q;
    assign exponent_out = exp2_q;
    assign grs_out      = grs_q;
endmodule
